// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter with start/ready/valid handshake.
// One conversion takes binWidth shift cycles; the result and the overflow flag hold until the next completion.
module bin_to_bcd #(
  parameter int binWidth = 8,
  parameter int digits   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [binWidth-1:0]   bin,
  output logic                  ready,
  output logic [4*digits-1:0]   bcd,
  output logic                  valid,
  output logic                  overflow
);

  localparam int BW = 4 * digits;
  localparam int CW = $clog2(binWidth + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [binWidth-1:0] shift_q, shift_d;
  logic [BW-1:0]       scratch_q, scratch_d;
  logic                ovf_q, ovf_d;
  logic [CW-1:0]       count_q, count_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       shifted_scratch;
  logic                shift_out;

  // Per-digit +3 correction, modulo 16, applied to all digits in parallel.
  generate
    for (genvar gi = 0; gi < digits; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ? scratch_q[gi*4 +: 4] + 4'd3
                                                             : scratch_q[gi*4 +: 4];
    end
  endgenerate

  assign shifted_scratch = {adj[BW-2:0], shift_q[binWidth-1]};
  assign shift_out       = adj[BW-1];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          shift_d   = bin;
          scratch_d = '0;
          ovf_d     = 1'b0;
          count_d   = CW'(binWidth);
          state_d   = CONV;
        end
      end
      CONV: begin
        shift_d   = shift_q << 1;
        scratch_d = shifted_scratch;
        ovf_d     = ovf_q | shift_out;
        count_d   = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          bcd_d      = shifted_scratch;
          overflow_d = ovf_q | shift_out;
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // All outputs come straight from flops, so en/bin never reach them combinationally.
  assign ready    = (state_q == IDLE);
  assign bcd      = bcd_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
- Sequential double-dabble converter. Sits directly downstream of the calculator multiplier: takes the unsigned binary product and produces packed BCD digits for the display/output stage.
- One conversion runs at a time and takes binWidth shift cycles.
- Start/ready/valid handshake; the result is held stable until the next conversion completes.

Parameters:
- binWidth, 8, width of the unsigned binary input (multiplier product width, 2*inSize).
- digits, 3, number of BCD output digits; bcd width is 4*digits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start request; sampled only when ready=1.
- bin  input  binWidth  unsigned binary value; captured on the accepting edge.
- ready  output  1  high when idle and able to accept en.
- bcd  output  4*digits  packed BCD result, digit 0 in bits [3:0]; held between conversions.
- valid  output  1  one-cycle pulse when bcd/overflow update.
- overflow  output  1  result did not fit in the available digits; held with bcd.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - state=IDLE; ready=1; valid=0; bcd=0; overflow=0.
  - Internal shift, scratch BCD and counter cleared.
  - Any in-flight conversion is discarded.
- States: IDLE, CONV, DONE.
- IDLE:
  - ready=1.
  - On an edge with en=1: shift reg<=bin; scratch BCD<=0; ovf accumulator<=0; count<=binWidth; go to CONV.
  - en=0: stay in IDLE.
- CONV, each edge:
  - First, each scratch digit >=5 gets +3 (4-bit, per digit, applied in parallel).
  - Then {scratch, shift reg} shifts left by 1.
  - The bit leaving the top of scratch ORs into the ovf accumulator.
  - count decrements.
  - On the edge where count is 1 (last shift): bcd<=adjusted+shifted scratch; overflow<=accumulator OR'd with this edge's shifted-out bit; valid<=1; go to DONE.
- DONE:
  - valid=1 for exactly this one cycle; ready=0.
  - Next edge: valid<=0; go to IDLE.
  - en in DONE is ignored.
- Timing for an accept edge E0:
  - Conversion edges are E1..E_binWidth.
  - bcd, overflow and valid change at E_binWidth.
  - ready returns high at E_binWidth+1.
  - Throughput: one conversion per binWidth+2 cycles with en held high.
- en while ready=0 (CONV or DONE): ignored, not queued.
- bin changes after the accept edge have no effect on the running conversion.
- bcd and overflow hold their last values until the next DONE entry; they do not clear when a new conversion starts.
- Widths:
  - Scratch BCD register is 4*digits bits; the digit adjust is modulo 16 per digit, and with a correct sequence it never wraps.
  - Overflow means the true value is >= 10^digits. In that case bcd holds the low-order digits only and is undefined as a decimal value; consumers must check overflow.
- binWidth=1 is legal: a single CONV edge goes straight to DONE.
- No combinational path from en or bin to any output.

Test Plan:
- Reset then idle (binWidth=8, digits=3): rst pulse mid-cycle -> outputs clear immediately without a clock edge; ready=1, bcd=0x000, valid=0, overflow=0.
- Basic conversion: bin=8'd225, en pulse at E0 -> valid high for one cycle after E8, bcd=12'h225, overflow=0, ready=1 after E9.
- Boundaries:
  - bin=0 -> bcd=12'h000.
  - bin=255 -> bcd=12'h255.
  - bin=99 -> bcd=12'h099.
  - All with overflow=0 and latency 8.
- Overflow (digits=2 instance): bin=8'd150 -> overflow=1, valid pulse after E8. bin=8'd99 -> bcd=8'h99, overflow=0.
- Handshake:
  - en held high continuously with bin=37, then 64 -> conversions accepted every 10 cycles; results 0x037, then 0x064.
  - en pulses during CONV/DONE are ignored and do not extend or restart the conversion.
  - bcd holds 0x037 until the second valid.
- Reset mid-operation: start bin=200, assert rst at cycle 4 of CONV -> immediate return to IDLE with cleared outputs and no valid pulse. A new en with bin=42 then yields bcd=0x042 after 8 cycles.
